uart_rx: RTL and testbench

- Serial receiver for the board's rx232 RS-232 input, complementing the tx232 transmit path.
- Recovers 8N1 frames (8 data bits, no parity, 1 stop bit) using 16x oversampling on the 48 MHz system clock.
- Delivers each byte as a one-cycle strobe to the host-command / key-injection logic.
- Has no backpressure; the consumer must capture data in the strobe cycle.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling for the rx232 line.
// Delivers each byte as a one-cycle rx_valid strobe; no backpressure.
// Optional: define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse.
// Handshake: rx_valid, frame_err and parity_err are single-cycle pulses with
// no ready; the consumer must capture rx_data in the cycle rx_valid is high.
module uart_rx #(
    parameter int CLK_HZ = 48000000,
    parameter int BAUD   = 115200,
    parameter int OS_DIV = CLK_HZ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       break_det,
    output logic       busy
);

    localparam int OS_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [1:0]      sync_ok;
    logic            armed;
    logic [OS_W-1:0] os_cnt;
    logic            tick;
    logic [3:0]      scnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            start_evt;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad;
`endif

    // Two-flop synchronizer; sync_ok marks when rxs reflects the line sampled
    // after reset rather than the preset value, so a line held low at reset
    // release cannot arm the start detector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            sync_ok <= 2'b00;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            sync_ok <= {sync_ok[0], 1'b1};
        end
    end

    assign start_evt = (state == IDLE) && armed && !rxs;
    assign tick      = (os_cnt == OS_W'(OS_DIV - 1));
    assign busy      = (state != IDLE);

    // Oversample tick divider, re-phased to the start edge so that tick 8 of
    // the start bit falls at its middle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            os_cnt <= '0;
        end else if (start_evt || tick) begin
            os_cnt <= '0;
        end else begin
            os_cnt <= os_cnt + OS_W'(1);
        end
    end

    // Receive FSM: start validation, data shifting, stop check, break hold-off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            scnt      <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rxs && sync_ok[1]) armed <= 1'b1;
                    if (start_evt) begin
                        state <= START;
                        scnt  <= 4'd0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt == 4'd7) begin
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                scnt    <= 4'd0;
                                bit_idx <= 3'd0;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (scnt == 4'd15) begin
                            shift_reg <= {rxs, shift_reg[7:1]};
                            scnt      <= 4'd0;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (scnt == 4'd15) begin
                            parity_bad <= rxs ^ (^shift_reg);
                            scnt       <= 4'd0;
                            state      <= STOP;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (scnt == 4'd15) begin
                            scnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
                            parity_err <= parity_bad;
`endif
                            if (rxs) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                if (shift_reg == 8'h00) break_det <= 1'b1;
                                state <= WAIT_HIGH;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        break_det <= 1'b0;
                        armed     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Runs every scenario at the
// nominal bit period and at +3% / -3% sender rate. The receiver is built
// with BAUD chosen so OS_DIV = 8 (128 clk per bit) to keep runs short.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ  = 48000000;
    localparam int BAUD    = 375000;
    localparam int BIT_NOM = 128;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       break_det;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .break_det (break_det),
        .busy      (busy)
    );

    // 48 MHz clock
    always #10.417 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe is checked against the expected byte queue.
    always @(negedge clk) begin
        cyc++;
        if (rx_valid || frame_err)
            check("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
        if (parity_err) check("parity_err", {31'd0, parity_err}, 32'd0);
`endif
        if (rx_valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_valid: observed rx_data %02h expected no strobe", rx_data);
            end
            if (exp_q.size() != 0) check("rx_data_stream", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int bc);
        rx = b;
        wait_clks(bc);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_bit);
        send_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) send_bit(b[i], bc);
`ifdef UART_RX_PARITY_EN
        send_bit(^b, bc);
`endif
        send_bit(stop_bit, bc);
    endtask

    task automatic run_round(input int bc);
        int v0;
        int f0;
        int gap;

        // Reset with the line idle
        rx = 1'b1;
        reset_n = 1'b0;
        wait_clks(3);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_break_det", {31'd0, break_det}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        wait_clks(bc);

        // Single good frame
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, bc, 1'b1);
        wait_clks(bc);
        check("b55_valid_count", valid_cnt - v0, 32'd1);
        check("b55_ferr_count", ferr_cnt - f0, 32'd0);
        check("b55_busy_after", {31'd0, busy}, 32'd0);
        check("b55_rx_data", {24'd0, rx_data}, 32'h55);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt;
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_byte(8'hA3, bc, 1'b1);
        send_byte(8'h0F, bc, 1'b1);
        wait_clks(bc);
        gap = last_valid_cyc - prev_valid_cyc;
        check("b2b_valid_count", valid_cnt - v0, 32'd2);
        check("b2b_gap_in_range",
              {31'd0, (gap >= FRAME_BITS * bc - 2) && (gap <= FRAME_BITS * bc + 2)}, 32'd1);
        check("b2b_rx_data", {24'd0, rx_data}, 32'h0F);

        // Short low glitch on idle line (about 200 ns)
        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(10);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        wait_clks(bc - 20);
        check("glitch_busy_after", {31'd0, busy}, 32'd0);
        check("glitch_valid_count", valid_cnt - v0, 32'd0);
        check("glitch_ferr_count", ferr_cnt - f0, 32'd0);

        // Stop bit forced low, then a good frame
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, bc, 1'b0);
        rx = 1'b1;
        wait_clks(bc);
        check("badstop_ferr_count", ferr_cnt - f0, 32'd1);
        check("badstop_valid_count", valid_cnt - v0, 32'd0);
        check("badstop_rx_data_kept", {24'd0, rx_data}, 32'h0F);
        check("badstop_break_det", {31'd0, break_det}, 32'd0);
        check("badstop_busy_after", {31'd0, busy}, 32'd0);
        v0 = valid_cnt;
        exp_q.push_back(8'h81);
        send_byte(8'h81, bc, 1'b1);
        wait_clks(bc);
        check("b81_valid_count", valid_cnt - v0, 32'd1);
        check("b81_rx_data", {24'd0, rx_data}, 32'h81);

        // Line held low for 20 bit periods
        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(20 * bc);
        check("break_ferr_count", ferr_cnt - f0, 32'd1);
        check("break_valid_count", valid_cnt - v0, 32'd0);
        check("break_det_held", {31'd0, break_det}, 32'd1);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_clks(6);
        check("break_det_cleared", {31'd0, break_det}, 32'd0);
        wait_clks(bc);
        v0 = valid_cnt;
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, bc, 1'b1);
        wait_clks(bc);
        check("b7e_valid_count", valid_cnt - v0, 32'd1);
        check("b7e_rx_data", {24'd0, rx_data}, 32'h7E);

        // Reset midway through a 0xFF frame with the line low at release
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b0, bc);
        send_bit(1'b1, 3 * bc);
        rx = 1'b0;
        wait_clks(bc / 2);
        reset_n = 1'b0;
        wait_clks(1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        reset_n = 1'b1;
        wait_clks(3 * bc);
        check("midrst_no_false_start", {31'd0, busy}, 32'd0);
        check("midrst_valid_count", valid_cnt - v0, 32'd0);
        check("midrst_ferr_count", ferr_cnt - f0, 32'd0);
        rx = 1'b1;
        wait_clks(2 * bc);
        exp_q.push_back(8'h42);
        send_byte(8'h42, bc, 1'b1);
        wait_clks(bc);
        check("b42_valid_count", valid_cnt - v0, 32'd1);
        check("b42_rx_data", {24'd0, rx_data}, 32'h42);
    endtask

    initial begin
        run_round(BIT_NOM);
        run_round(124);
        run_round(132);
        wait_clks(10);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
